// File: rtl/router_pkt_tx.sv
// Host-side packet source for the router input port: buffers a payload, then sends header, payload and XOR parity.
// Optional build macro TX_PARITY_CORRUPT_EN adds corrupt_par, which makes the transmitted parity byte inverted.
module router_pkt_tx #(
    parameter int MAX_LEN = 63,
    parameter int BUF_AW  = 6
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] addr,
    input  logic [5:0] len,
`ifdef TX_PARITY_CORRUPT_EN
    input  logic       corrupt_par,
`endif
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_busy,
    output logic       done,
    output logic       req_err
);

    typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY} state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        addr_q;
    logic [5:0]        len_q;
    logic [BUF_AW-1:0] wcnt;
    logic [BUF_AW-1:0] rcnt;
    logic [BUF_AW-1:0] last_idx;
    logic [7:0]        parity_q;
    logic [7:0]        parity_tx;
    logic [7:0]        pkt_buf [2**BUF_AW];
    logic              req_ok;

    assign req_ok   = (len != 6'd0) && (addr != 2'd3) && (int'(len) <= MAX_LEN);
    assign last_idx = BUF_AW'(len_q - 6'd1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && req_ok) state_next = LOAD;
            LOAD:    if (pl_valid && wcnt == last_idx) state_next = HEADER;
            HEADER:  if (!busy) state_next = PAYLOAD;
            PAYLOAD: if (!busy && rcnt == last_idx) state_next = PARITY;
            PARITY:  if (!busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode registered state only, so busy/pl_valid never reach them combinationally.
    always_comb begin
        pl_ready  = (state == LOAD);
        pkt_valid = (state == HEADER) || (state == PAYLOAD);
        tx_busy   = (state != IDLE);
        data_out  = 8'h00;
        case (state)
            HEADER:  data_out = {len_q, addr_q};
            PAYLOAD: data_out = pkt_buf[rcnt];
            PARITY:  data_out = parity_tx;
            default: data_out = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && pl_valid) begin
            pkt_buf[wcnt] <= pl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q   <= 2'd0;
            len_q    <= 6'd0;
            wcnt     <= '0;
            rcnt     <= '0;
            parity_q <= 8'h00;
            done     <= 1'b0;
            req_err  <= 1'b0;
        end else begin
            done    <= 1'b0;
            req_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (req_ok) begin
                            addr_q   <= addr;
                            len_q    <= len;
                            parity_q <= {len, addr};
                            wcnt     <= '0;
                        end else begin
                            req_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (pl_valid) begin
                        parity_q <= parity_q ^ pl_data;
                        wcnt     <= wcnt + 1'b1;
                    end
                end
                HEADER: begin
                    if (!busy) rcnt <= '0;
                end
                PAYLOAD: begin
                    if (!busy) rcnt <= rcnt + 1'b1;
                end
                PARITY: begin
                    if (!busy) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef TX_PARITY_CORRUPT_EN
    logic corrupt_q;

    // The corrupt request belongs to one packet only; it is dropped once the parity byte leaves.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            corrupt_q <= 1'b0;
        end else if (state == IDLE && start && req_ok) begin
            corrupt_q <= corrupt_par;
        end else if (state == PARITY && !busy) begin
            corrupt_q <= 1'b0;
        end
    end

    assign parity_tx = corrupt_q ? ~parity_q : parity_q;
`else
    assign parity_tx = parity_q;
`endif

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed packets plus randomized payload, gaps and backpressure.
// The expected byte stream is built from the packet format rules, independent of the design internals.
module tb_router_pkt_tx;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_busy;
    logic       done;
    logic       req_err;
`ifdef TX_PARITY_CORRUPT_EN
    logic       corrupt_par;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] pl_bytes[$];

    router_pkt_tx dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .addr      (addr),
        .len       (len),
`ifdef TX_PARITY_CORRUPT_EN
        .corrupt_par(corrupt_par),
`endif
        .pl_valid  (pl_valid),
        .pl_data   (pl_data),
        .pl_ready  (pl_ready),
        .busy      (busy),
        .data_out  (data_out),
        .pkt_valid (pkt_valid),
        .tx_busy   (tx_busy),
        .done      (done),
        .req_err   (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_data_out"}, 32'(data_out), 32'h00);
        check_output({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
        check_output({tag, "_pl_ready"}, 32'(pl_ready), 32'd0);
        check_output({tag, "_tx_busy"}, 32'(tx_busy), 32'd0);
    endtask

    // gap: idle cycles before each payload byte (-1 = random 0..2)
    // busy_mode: 0 none, 1 random, 2 three-cycle stall while payload index stall_idx-1 is shown
    // abort_at: stop (without finishing) when stream position abort_at is about to be presented
    task automatic send_packet(input logic [1:0] a, input logic [5:0] l, input int gap,
                               input int busy_mode, input int stall_idx, input int abort_at,
                               input bit corrupt);
        logic [7:0] exp_b[$];
        bit         exp_v[$];
        logic [7:0] par;
        int         g;
        int         k;
        int         n;
        int         stall;

        if (pl_bytes.size() == 0) begin
            for (int i = 0; i < int'(l); i++) pl_bytes.push_back(8'($urandom));
        end
        par = {l, a};
        exp_b.push_back({l, a});
        exp_v.push_back(1'b1);
        foreach (pl_bytes[i]) begin
            exp_b.push_back(pl_bytes[i]);
            exp_v.push_back(1'b1);
            par = par ^ pl_bytes[i];
        end
        exp_b.push_back(corrupt ? ~par : par);
        exp_v.push_back(1'b0);

        start    = 1'b1;
        addr     = a;
        len      = l;
        pl_valid = 1'b0;
        busy     = 1'b0;
`ifdef TX_PARITY_CORRUPT_EN
        corrupt_par = corrupt;
`endif
        step();
        check_output("load_entry_tx_busy", 32'(tx_busy), 32'd1);
        check_output("load_entry_done", 32'(done), 32'd0);

        for (int i = 0; i < int'(l); i++) begin
            g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
            for (int j = 0; j <= g; j++) begin
                start    = 1'($urandom_range(1, 0));
                addr     = 2'($urandom_range(2, 0));
                len      = 6'd0;
                pl_valid = (j == g);
                pl_data  = (j == g) ? pl_bytes[i] : 8'($urandom);
                check_output("load_pl_ready", 32'(pl_ready), 32'd1);
                check_output("load_pkt_valid", 32'(pkt_valid), 32'd0);
                check_output("load_req_err", 32'(req_err), 32'd0);
                step();
            end
        end
        pl_valid = 1'b0;
        pl_data  = 8'($urandom);

        k = 0;
        n = 0;
        stall = 0;
        while (k < exp_b.size() && n < 4 * exp_b.size() + 20) begin
            if (abort_at >= 0 && k == abort_at) break;
            case (busy_mode)
                1:       busy = 1'($urandom_range(3, 0) == 0);
                2:       busy = (k == stall_idx) && (stall < 3);
                default: busy = 1'b0;
            endcase
            if (busy) stall++;
            start = 1'($urandom_range(1, 0));
            len   = 6'd0;
            check_output($sformatf("stream_byte%0d", k), 32'(data_out), 32'(exp_b[k]));
            check_output($sformatf("stream_valid%0d", k), 32'(pkt_valid), 32'(exp_v[k]));
            check_output("stream_pl_ready", 32'(pl_ready), 32'd0);
            check_output("stream_done", 32'(done), 32'd0);
            check_output("stream_req_err", 32'(req_err), 32'd0);
            step();
            n++;
            if (!busy) k++;
        end
        busy  = 1'b0;
        start = 1'b0;
        pl_bytes.delete();
        if (abort_at >= 0) begin
            check_output("abort_reached", 32'(k), 32'(abort_at));
            return;
        end
        check_output("stream_complete", 32'(k), 32'(exp_b.size()));
        if (busy_mode == 0) check_output("stream_cycles", 32'(n), 32'(int'(l) + 2));
        check_output("done_pulse", 32'(done), 32'd1);
        check_idle_outputs("after_packet");
    endtask

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        addr     = 2'd0;
        len      = 6'd0;
        pl_valid = 1'b0;
        pl_data  = 8'h00;
        busy     = 1'b0;
`ifdef TX_PARITY_CORRUPT_EN
        corrupt_par = 1'b0;
`endif
        step();
        step();
        check_idle_outputs("reset");
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_req_err", 32'(req_err), 32'd0);
        resetn = 1'b1;
        step();

        $display("[TB] basic packet addr=1 len=3");
        pl_bytes = '{8'hA5, 8'h3C, 8'h0F};
        send_packet(2'd1, 6'd3, 0, 0, 0, -1, 1'b0);

        $display("[TB] same packet, busy stall on 0x3C, started in the done cycle");
        pl_bytes = '{8'hA5, 8'h3C, 8'h0F};
        send_packet(2'd1, 6'd3, 0, 2, 2, -1, 1'b0);
        step();
        check_output("done_single_cycle", 32'(done), 32'd0);

        $display("[TB] addr=2 len=1 with pl_valid gaps");
        pl_bytes = '{8'hFF};
        send_packet(2'd2, 6'd1, 2, 0, 0, -1, 1'b0);
        step();

        $display("[TB] rejected requests");
        start = 1'b1; addr = 2'd1; len = 6'd0;
        step();
        start = 1'b0;
        check_output("len0_req_err", 32'(req_err), 32'd1);
        check_idle_outputs("len0");
        step();
        check_output("len0_req_err_clear", 32'(req_err), 32'd0);
        start = 1'b1; addr = 2'd3; len = 6'd5;
        step();
        start = 1'b0;
        check_output("addr3_req_err", 32'(req_err), 32'd1);
        check_idle_outputs("addr3");
        step();
        check_output("addr3_req_err_clear", 32'(req_err), 32'd0);
        check_idle_outputs("addr3_after");

        $display("[TB] reset during payload");
        send_packet(2'd0, 6'd10, 0, 0, 0, 4, 1'b0);
        resetn = 1'b0;
        step();
        check_idle_outputs("midreset");
        check_output("midreset_done", 32'(done), 32'd0);
        resetn = 1'b1;
        step();
        check_idle_outputs("midreset_after");
        send_packet(2'd2, 6'd2, -1, 0, 0, -1, 1'b0);

        $display("[TB] randomized packets");
        for (int p = 0; p < 8; p++) begin
            send_packet(2'($urandom_range(2, 0)), 6'($urandom_range(20, 1)), -1, 1, 0, -1, 1'b0);
            if (p[0]) step();
        end

        $display("[TB] maximum length packet");
        send_packet(2'd1, 6'd63, -1, 1, 0, -1, 1'b0);

`ifdef TX_PARITY_CORRUPT_EN
        $display("[TB] corrupted parity");
        pl_bytes = '{8'hA5, 8'h3C, 8'h0F};
        send_packet(2'd1, 6'd3, 0, 0, 0, -1, 1'b1);
        pl_bytes = '{8'hA5, 8'h3C, 8'h0F};
        send_packet(2'd1, 6'd3, 0, 0, 0, -1, 1'b0);
`endif

        step();
        check_output("final_done", 32'(done), 32'd0);
        check_idle_outputs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for the 1x3 router input port. It drives the byte stream that the router's input register stage consumes.
- Stages a payload from an upstream byte stream into an internal buffer.
- Emits header, payload bytes and a trailing XOR parity byte on data_out/pkt_valid.
- Honours the router's busy backpressure.
- Used as the stimulus/host-side transmitter in the router subsystem and its benches.

Parameters:
- MAX_LEN, 63, maximum payload length in bytes. Must match the 6-bit length field.
- BUF_AW, 6, buffer address width. Buffer depth is 2**BUF_AW and must be >= MAX_LEN.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request to send one packet. Sampled only in IDLE.
- addr  in  2  destination port (0..2). Sampled with start.
- len  in  6  payload byte count (1..63). Sampled with start.
- pl_valid  in  1  upstream payload byte valid.
- pl_data  in  8  upstream payload byte.
- pl_ready  out  1  block accepts pl_data this cycle.
- busy  in  1  router backpressure. When high, the current output byte is held.
- data_out  out  8  byte to router.
- pkt_valid  out  1  high for header and payload bytes; low for the parity byte and when idle.
- tx_busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the parity byte is transferred.
- req_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE.
  - pl_ready=0, data_out=0, pkt_valid=0, tx_busy=0, done=0, req_err=0.
  - Counters=0, parity accumulator=0. Buffer contents are don't-care.
  - Reset mid-packet aborts immediately; no parity byte is sent.
- All outputs are registered or decoded from registered state only. No combinational path from busy or pl_valid to outputs.
- Header byte = {len[5:0], addr[1:0]}.
- Parity = 8-bit XOR of header and all payload bytes.
- Transfer rule: a byte is transferred at a rising edge where the state is HEADER, PAYLOAD or PARITY and busy=0. With busy=1, data_out and pkt_valid hold unchanged.
- IDLE:
  - pl_ready=0, data_out=0, pkt_valid=0.
  - start=1 with len==0 or addr==3: req_err pulses next cycle; stay IDLE.
  - start=1 with a valid request: latch addr/len, parity<=header, wcnt<=0, go to LOAD.
- LOAD:
  - pl_ready=1.
  - Each cycle with pl_valid=1: buf[wcnt]<=pl_data, parity^=pl_data, wcnt++.
  - On accepting byte index len-1: pl_ready drops next cycle, go to HEADER.
  - pl_valid gaps are allowed and have no timeout. pkt_valid stays 0 throughout LOAD.
- HEADER: data_out=header, pkt_valid=1. On transfer: rcnt<=0, go to PAYLOAD.
- PAYLOAD:
  - data_out=buf[rcnt], pkt_valid=1.
  - On transfer: rcnt++.
  - On transfer of index len-1: go to PARITY.
- PARITY: data_out=parity, pkt_valid=0. On transfer: go to IDLE, done=1 for exactly one cycle.
- Latency, busy held low:
  - Header appears on the cycle after the last LOAD accept.
  - The packet occupies len+2 consecutive cycles on data_out.
  - done is asserted on the first IDLE cycle.
- start while tx_busy=1 is ignored; there is no queuing. start in the same cycle as done is honoured, since the state is IDLE.
- busy asserted mid-payload stalls the stream without duplication or loss. Parity is unaffected.

Optional Feature:
- Macro TX_PARITY_CORRUPT_EN.
- Defined:
  - Adds input port corrupt_par (1 bit), sampled with an accepted start.
  - If it was set, the PARITY byte is transmitted as ~parity. Used to provoke the router's error flag.
  - The latched flag clears on reset and on return to IDLE.
- Not defined: the port is absent and parity is always correct.

Test Plan:
1. addr=1, len=3, payload A5,3C,0F, busy=0 -> data_out sequence 0x0D,0xA5,0x3C,0x0F,0x9B. pkt_valid 1,1,1,1,0 on consecutive cycles. done pulses once.
2. Same packet with busy=1 for 3 cycles while 0x3C is presented -> 0x3C held 4 cycles with pkt_valid=1. Final parity is still 0x9B, no duplicate bytes.
3. addr=2, len=1, payload FF, pl_valid with 2-cycle gaps -> pl_ready high for the whole LOAD. Output 0x06,0xFF,0xF9.
4. start with len=0, then start with addr=3 -> req_err pulses each time, tx_busy stays 0, no bytes emitted.
5. resetn=0 during PAYLOAD of a len=10 packet -> next cycle all outputs are 0 and state is IDLE. A following len=2 packet sends correct header and parity.
6. With TX_PARITY_CORRUPT_EN, repeat test 1 with corrupt_par=1 -> parity byte 0x64. Repeat with corrupt_par=0 -> 0x9B.
